// File: rtl/muldiv_sequencer_if.sv
// Control/unit handshake bundle for muldiv_sequencer.
// master = control FSM plus mult/div units, slave = the sequencer.
interface muldiv_sequencer_if;
  logic start;
  logic op;
  logic flush;
  logic MtoC;
  logic DtoC;
  logic DivZero;
  logic CtoM;
  logic CtoD;
  logic divOrMul;
  logic writeH;
  logic writeL;
  logic busy;
  logic done;
  logic div_zero_err;
  logic timeout_err;

  modport master (
    output start, op, flush, MtoC, DtoC, DivZero,
    input  CtoM, CtoD, divOrMul, writeH, writeL, busy, done, div_zero_err, timeout_err
  );

  modport slave (
    input  start, op, flush, MtoC, DtoC, DivZero,
    output CtoM, CtoD, divOrMul, writeH, writeL, busy, done, div_zero_err, timeout_err
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one mult/div request: unit handshake, div-by-zero trap, HI/LO write, done pulse.
// Optional WAIT watchdog enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input logic               clock,
  input logic               Reset,
  muldiv_sequencer_if.slave bus
);

  localparam int unsigned ST_W = 4;

  localparam logic [ST_W-1:0] S_IDLE      = 4'd0;
  localparam logic [ST_W-1:0] S_MUL_START = 4'd1;
  localparam logic [ST_W-1:0] S_DIV_START = 4'd2;
  localparam logic [ST_W-1:0] S_MUL_WAIT  = 4'd3;
  localparam logic [ST_W-1:0] S_DIV_WAIT  = 4'd4;
  localparam logic [ST_W-1:0] S_WRITE_HL  = 4'd5;
  localparam logic [ST_W-1:0] S_DONE      = 4'd6;
  localparam logic [ST_W-1:0] S_ERR_DZ    = 4'd7;
`ifdef MULDIV_TIMEOUT_EN
  localparam logic [ST_W-1:0] S_ERR_TO    = 4'd8;
`endif

  // Elaborates an empty marker block when the counter cannot hold TIMEOUT_CYCLES.
  if (CNT_W < 32 && TIMEOUT_CYCLES > ((32'd1 << CNT_W) - 32'd1)) begin : g_err_cnt_w_too_narrow
  end

  logic [ST_W-1:0] state_q, state_d;
  logic            op_q, op_d;
  logic            expired_c;

  logic ctom_q, ctom_d;
  logic ctod_q, ctod_d;
  logic dom_q, dom_d;
  logic wr_q, wr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic dz_q, dz_d;

`ifdef MULDIV_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  // cnt_q counts WAIT cycles already spent; this cycle is the last one allowed.
  assign expired_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == S_MUL_WAIT || state_q == S_DIV_WAIT) && state_d == state_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign to_d            = (state_d == S_ERR_TO);
  assign bus.timeout_err = to_q;
`else
  assign expired_c       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; flush overrides everything once busy.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          state_d = bus.op ? S_DIV_START : S_MUL_START;
        end
      end
      S_MUL_START: state_d = bus.MtoC ? S_WRITE_HL : S_MUL_WAIT;
      S_DIV_START: begin
        if (bus.DtoC) state_d = bus.DivZero ? S_ERR_DZ : S_WRITE_HL;
        else          state_d = S_DIV_WAIT;
      end
      S_MUL_WAIT: begin
        if (bus.MtoC) state_d = S_WRITE_HL;
`ifdef MULDIV_TIMEOUT_EN
        else if (expired_c) state_d = S_ERR_TO;
`endif
      end
      S_DIV_WAIT: begin
        if (bus.DtoC) state_d = bus.DivZero ? S_ERR_DZ : S_WRITE_HL;
`ifdef MULDIV_TIMEOUT_EN
        else if (expired_c) state_d = S_ERR_TO;
`endif
      end
      S_WRITE_HL: state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
    if (bus.flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end
  end

  // Outputs decoded from the next state so they leave registers aligned with state_q.
  always_comb begin
    ctom_d = 1'b0;
    ctod_d = 1'b0;
    dom_d  = 1'b0;
    wr_d   = 1'b0;
    done_d = 1'b0;
    dz_d   = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_MUL_START: ctom_d = 1'b1;
      S_DIV_START: begin
        ctod_d = 1'b1;
        dom_d  = op_d;
      end
      S_DIV_WAIT:  dom_d = op_d;
      S_WRITE_HL: begin
        wr_d  = 1'b1;
        dom_d = op_d;
      end
      S_DONE: begin
        done_d = 1'b1;
        dom_d  = op_d;
      end
      S_ERR_DZ:    dz_d = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      ctom_q <= 1'b0;
      ctod_q <= 1'b0;
      dom_q  <= 1'b0;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      ctom_q <= ctom_d;
      ctod_q <= ctod_d;
      dom_q  <= dom_d;
      wr_q   <= wr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign bus.CtoM         = ctom_q;
  assign bus.CtoD         = ctod_q;
  assign bus.divOrMul     = dom_q;
  assign bus.writeH       = wr_q;
  assign bus.writeL       = wr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.div_zero_err = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer; expected traces come from the latency rules
// (CtoX at n+1, write at k+1, done at k+2, flush zeroes everything after its cycle).
module tb_muldiv_sequencer;

  localparam int TO  = 8;
  localparam int NOF = 1000;
`ifdef MULDIV_TIMEOUT_EN
  localparam int MAX_L = TO + 1;
`else
  localparam int MAX_L = 40;
`endif

  logic clock = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [8:0] obs [0:63];
  int   n_obs;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [8:0] out_vec();
    return {bus.CtoM, bus.CtoD, bus.divOrMul, bus.writeH, bus.writeL,
            bus.busy, bus.done, bus.div_zero_err, bus.timeout_err};
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 1'b0; bus.flush = 1'b0;
    bus.MtoC = 1'b0; bus.DtoC = 1'b0; bus.DivZero = 1'b0;
  endtask

  // Expected {CtoM,CtoD,divOrMul,writeH,writeL,busy,done,dz_err,to_err} in cycle c after start at 0.
  function automatic logic [8:0] exp_vec(int c, bit op_v, int L, bit dz, int f, bit to);
    bit ok;
    int e_end, e_dom;
    if (c < 1 || c > f) return '0;
    ok    = !dz && !to;
    e_end = to ? TO + 2 : (ok ? L + 2 : L + 1);
    e_dom = to ? TO + 1 : (ok ? L + 2 : L);
    return {c == 1 && !op_v, c == 1 && op_v, op_v && !to && c <= e_dom,
            ok && c == L + 1, ok && c == L + 1, c <= e_end, ok && c == L + 2,
            dz && !to && c == L + 1, to && c == TO + 2};
  endfunction

  // Plays one transaction: start at cycle 0, own-unit done at cycle L, optional flush at f.
  task automatic drive_txn(input bit op_v, input int L, input bit dz, input int f, input bit to,
                           input logic [63:0] xs, input logic [63:0] xo, input logic [63:0] xz);
    int  e_end;
    bit  own;
    e_end = to ? TO + 2 : (dz ? L + 1 : L + 2);
    n_obs = e_end + 3;
    for (int c = 0; c < n_obs; c++) begin
      obs[c]    = out_vec();
      own       = !to && (c == L);
      bus.start = (c == 0) || xs[c];
      bus.op    = (c == 0) ? op_v : 1'($urandom);
      bus.MtoC  = op_v ? xo[c] : own;
      bus.DtoC  = op_v ? own : xo[c];
      bus.DivZero = own ? dz : xz[c];
      bus.flush = (c == f);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (out_vec() !== 9'h000) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", out_vec(), 9'h000);
    end
    Reset = 1'b1;
    tick();
    n_tests++;
    if (out_vec() !== 9'h000) begin
      n_fail++; $display("FAIL post_reset_idle: got %b want %b", out_vec(), 9'h000);
    end
  endtask

  task automatic test_mult();
    logic [8:0] e;
    drive_txn(1'b0, 5, 1'b0, NOF, 1'b0, '0, '0, '0);
    for (int c = 0; c < n_obs; c++) begin
      e = exp_vec(c, 1'b0, 5, 1'b0, NOF, 1'b0);
      n_tests++;
      if (obs[c] !== e) begin
        n_fail++; $display("FAIL mult cyc %0d: got %b want %b", c, obs[c], e);
      end
    end
  endtask

  task automatic test_div();
    logic [8:0] e;
    int L;
    L = (MAX_L < 34) ? MAX_L : 34;
    drive_txn(1'b1, L, 1'b0, NOF, 1'b0, '0, '0, '0);
    for (int c = 0; c < n_obs; c++) begin
      e = exp_vec(c, 1'b1, L, 1'b0, NOF, 1'b0);
      n_tests++;
      if (obs[c] !== e) begin
        n_fail++; $display("FAIL div cyc %0d: got %b want %b", c, obs[c], e);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [8:0] e;
    drive_txn(1'b1, 4, 1'b1, NOF, 1'b0, '0, '0, '0);
    for (int c = 0; c < n_obs; c++) begin
      e = exp_vec(c, 1'b1, 4, 1'b1, NOF, 1'b0);
      n_tests++;
      if (obs[c] !== e) begin
        n_fail++; $display("FAIL div_zero cyc %0d: got %b want %b", c, obs[c], e);
      end
    end
  endtask

  task automatic test_ignored();
    logic [8:0] e;
    logic [63:0] xs, xo;
    xs = '0; xs[2] = 1'b1; xs[3] = 1'b1;
    xo = '0; xo[3] = 1'b1; xo[4] = 1'b1;
    drive_txn(1'b0, 6, 1'b0, NOF, 1'b0, xs, xo, '1);
    for (int c = 0; c < n_obs; c++) begin
      e = exp_vec(c, 1'b0, 6, 1'b0, NOF, 1'b0);
      n_tests++;
      if (obs[c] !== e) begin
        n_fail++; $display("FAIL ignored_inputs cyc %0d: got %b want %b", c, obs[c], e);
      end
    end
  endtask

  // Flush: with same-cycle MtoC, in WRITE_HL, in DIV_START, in DONE.
  task automatic test_flush();
    logic [8:0] e;
    bit tb_op [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int tb_l  [4] = '{3, 4, 5, 2};
    int tb_f  [4] = '{3, 5, 1, 4};
    for (int k = 0; k < 4; k++) begin
      drive_txn(tb_op[k], tb_l[k], 1'b0, tb_f[k], 1'b0, '0, '0, '0);
      for (int c = 0; c < n_obs; c++) begin
        e = exp_vec(c, tb_op[k], tb_l[k], 1'b0, tb_f[k], 1'b0);
        n_tests++;
        if (obs[c] !== e) begin
          n_fail++; $display("FAIL flush%0d cyc %0d: got %b want %b", k, c, obs[c], e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.op = 1'b1;
    tick();
    bus.start = 1'b0; bus.op = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.busy !== 1'b1 || bus.divOrMul !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_busy: got busy=%b dom=%b want 1 1", bus.busy, bus.divOrMul);
    end
    #2 Reset = 1'b0;
    #1;
    n_tests++;
    if (out_vec() !== 9'h000) begin
      n_fail++; $display("FAIL async_reset: got %b want %b", out_vec(), 9'h000);
    end
    tick();
    Reset = 1'b1;
    tick();
    n_tests++;
    if (out_vec() !== 9'h000) begin
      n_fail++; $display("FAIL after_mid_reset: got %b want %b", out_vec(), 9'h000);
    end
  endtask

`ifdef MULDIV_TIMEOUT_EN
  task automatic test_timeout();
    logic [8:0] e;
    logic [63:0] xo;
    xo = '0; xo[4] = 1'b1;
    drive_txn(1'b0, 0, 1'b0, NOF, 1'b1, '0, xo, '0);
    for (int c = 0; c < n_obs; c++) begin
      e = exp_vec(c, 1'b0, 0, 1'b0, NOF, 1'b1);
      n_tests++;
      if (obs[c] !== e) begin
        n_fail++; $display("FAIL timeout cyc %0d: got %b want %b", c, obs[c], e);
      end
    end
    drive_txn(1'b1, TO + 1, 1'b0, NOF, 1'b0, '0, '0, '0);
    for (int c = 0; c < n_obs; c++) begin
      e = exp_vec(c, 1'b1, TO + 1, 1'b0, NOF, 1'b0);
      n_tests++;
      if (obs[c] !== e) begin
        n_fail++; $display("FAIL timeout_edge_done cyc %0d: got %b want %b", c, obs[c], e);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [8:0]  e;
    logic [63:0] xs, xo, xz;
    bit op_v, dz, to;
    int L, f, e_end;
    for (int t = 0; t < 40; t++) begin
      op_v = 1'($urandom);
      L    = $urandom_range(1, MAX_L);
      dz   = op_v && ($urandom_range(0, 3) == 0);
      to   = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      to   = ($urandom_range(0, 7) == 0);
`endif
      e_end = to ? TO + 2 : (dz ? L + 1 : L + 2);
      f     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, e_end) : NOF;
      xs = '0; xo = '0; xz = '0;
      for (int c = 1; c <= e_end && c <= f; c++) if ($urandom_range(0, 3) == 0) xs[c] = 1'b1;
      for (int c = 0; c < 64; c++) begin
        if ($urandom_range(0, 3) == 0) xo[c] = 1'b1;
        xz[c] = 1'($urandom);
      end
      drive_txn(op_v, L, dz, f, to, xs, xo, xz);
      for (int c = 0; c < n_obs; c++) begin
        e = exp_vec(c, op_v, L, dz, f, to);
        n_tests++;
        if (obs[c] !== e) begin
          n_fail++;
          $display("FAIL random t%0d op=%0d L=%0d dz=%0d f=%0d cyc %0d: got %b want %b",
                   t, op_v, L, dz, f, c, obs[c], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored();
    test_flush();
    test_reset_mid();
`ifdef MULDIV_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
